// File: rtl/conv_window_ctrl.sv
// Sequencer for the convolution line-buffer datapath: drives the shared shift
// enable and flags in-bounds windows with their output coordinates.
module conv_window_ctrl #(
    parameter int IMAGE_WIDTH  = 28,
    parameter int KERNEL_WIDTH = 5,
    parameter int CW           = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          shift_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_row,
    output logic [CW-1:0] out_col,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(IMAGE_WIDTH - 1);
    localparam logic [CW-1:0] KM1      = CW'(KERNEL_WIDTH - 1);

    state_t        r_state;
    logic [CW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic [CW-1:0] r_out_row;
    logic [CW-1:0] r_out_col;
    logic          r_out_valid;
    logic          r_busy;
    logic          r_frame_done;

    logic          w_stall;
    logic          w_in_ready;
    logic          w_accept;
    logic          w_win_hit;

    // Handshake decode: a held, unconsumed window blocks new pixels.
    always_comb begin
        w_stall = r_out_valid && !out_ready;
        if (r_state == S_RUN) begin
            w_in_ready = !w_stall;
        end else begin
            w_in_ready = 1'b0;
        end
        w_accept  = in_valid && w_in_ready;
        w_win_hit = w_accept && (r_row >= KM1) && (r_col >= KM1);
    end

    // Frame FSM, raster counters and registered window tag outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_row        <= {CW{1'b0}};
            r_col        <= {CW{1'b0}};
            r_out_row    <= {CW{1'b0}};
            r_out_col    <= {CW{1'b0}};
            r_out_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            // Window tag uses the pre-increment position of the accepted pixel.
            if (w_win_hit) begin
                r_out_valid <= 1'b1;
                r_out_row   <= r_row - KM1;
                r_out_col   <= r_col - KM1;
            end else if (w_stall) begin
                r_out_valid <= 1'b1;
            end else begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    r_frame_done <= 1'b0;
                    if (start) begin
                        r_state     <= S_RUN;
                        r_row       <= {CW{1'b0}};
                        r_col       <= {CW{1'b0}};
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b1;
                    end else begin
                        r_busy <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (r_col == LAST_IDX) begin
                            r_col <= {CW{1'b0}};
                            r_row <= r_row + {{(CW-1){1'b0}}, 1'b1};
                            if (r_row == LAST_IDX) begin
                                r_state <= S_DRAIN;
                            end else begin
                                r_state <= S_RUN;
                            end
                        end else begin
                            r_col <= r_col + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        r_col <= r_col;
                    end
                end
                S_DRAIN: begin
                    if (!w_stall) begin
                        r_state      <= S_DONE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    r_state      <= S_IDLE;
                    r_frame_done <= 1'b0;
                    r_busy       <= 1'b0;
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_busy       <= 1'b0;
                    r_frame_done <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign shift_en   = w_accept;
    assign out_valid  = r_out_valid;
    assign out_row    = r_out_row;
    assign out_col    = r_out_col;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule
